// File: rtl/lcd_sched_pkg.sv
// Shared definitions for the LCD command scheduler: opcodes, FSM encoding
// and the 23-bit command record handed to lcd_controller.
package lcd_sched_pkg;

   localparam logic [2:0] OP_LOAD  = 3'd0;
   localparam logic [2:0] OP_ADD   = 3'd1;
   localparam logic [2:0] OP_ADDI  = 3'd2;
   localparam logic [2:0] OP_SUB   = 3'd3;
   localparam logic [2:0] OP_SUBI  = 3'd4;
   localparam logic [2:0] OP_MUL   = 3'd5;
   localparam logic [2:0] OP_CLEAR = 3'd6;
   localparam logic [2:0] OP_DPL   = 3'd7;

   localparam logic GRANT_CPU = 1'b0;
   localparam logic GRANT_DBG = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_HOLD  = 2'd2
   } sched_state_e;

   typedef struct packed {
      logic [2:0]          opcode;
      logic [3:0]          reg_idx;
      logic signed [15:0]  value;
   } lcd_cmd_t;

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous FIFO with flush, full/empty flags and an occupancy count that
// reaches DEPTH inclusive. DEPTH must be a power of two so pointers wrap freely.
module lcd_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 23
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   input  logic                     flush,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW:0]      level_r;
   logic             do_push_s;
   logic             do_pop_s;

   // Qualify requests against the current flags.
   always_comb begin
      do_push_s = push && !full;
      do_pop_s  = pop && !empty;
   end

   // Pointers and occupancy; flush takes priority over any pop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         level_r  <= '0;
      end else if (flush) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         level_r  <= '0;
      end else begin
         if (do_push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
         if (do_pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
         case ({do_push_s, do_pop_s})
            2'b10:   level_r <= level_r + 1'b1;
            2'b01:   level_r <= level_r - 1'b1;
            default: level_r <= level_r;
         endcase
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (do_push_s) mem_r[wr_ptr_r] <= push_data;
   end

   assign head  = mem_r[rd_ptr_r];
   assign full  = (level_r == (AW+1)'(DEPTH));
   assign empty = (level_r == '0);
   assign level = level_r;

endmodule

// File: rtl/lcd_cmd_scheduler.sv
// Round-robin arbiter between the CPU request queue and the debug holding
// register, issuing one lcd_controller start pulse per hold-off window.
module lcd_cmd_scheduler
   import lcd_sched_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int HOLDOFF_CYCLES = 2_000_000
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          cpu_valid,
   output logic                          cpu_ready,
   input  logic [2:0]                    cpu_opcode,
   input  logic [3:0]                    cpu_reg_idx,
   input  logic signed [15:0]            cpu_value,
   input  logic                          dbg_valid,
   output logic                          dbg_ready,
   input  logic [2:0]                    dbg_opcode,
   input  logic [3:0]                    dbg_reg_idx,
   input  logic signed [15:0]            dbg_value,
   input  logic                          flush,
   output logic                          lcd_start,
   output logic [2:0]                    lcd_opcode,
   output logic [3:0]                    lcd_reg_idx,
   output logic signed [15:0]            lcd_value,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   cpu_level
);
   localparam int              CNT_W     = $clog2(HOLDOFF_CYCLES);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

   sched_state_e     state_r, state_nxt_s;
   logic [CNT_W-1:0] counter_r, counter_nxt_s;
   logic             last_grant_r;
   logic             lcd_start_r;
   logic             busy_r;
   lcd_cmd_t         lcd_cmd_r;
   lcd_cmd_t         cpu_cmd_s;
   lcd_cmd_t         fifo_head_s;
   lcd_cmd_t         dbg_cmd_r;
   logic             dbg_full_r;
   logic             fifo_full_s;
   logic             fifo_empty_s;
   logic             cpu_push_s;
   logic             dbg_load_s;
   logic             grant_cpu_s;
   logic             grant_dbg_s;

   assign cpu_cmd_s  = lcd_cmd_t'({cpu_opcode, cpu_reg_idx, cpu_value});
   assign cpu_ready  = !fifo_full_s && !flush;
   assign dbg_ready  = !dbg_full_r && !flush;
   assign cpu_push_s = cpu_valid && cpu_ready;
   assign dbg_load_s = dbg_valid && dbg_ready;

   lcd_cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(lcd_cmd_t))
   ) u_cpu_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (cpu_push_s),
      .push_data (cpu_cmd_s),
      .pop       (grant_cpu_s),
      .head      (fifo_head_s),
      .flush     (flush),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s),
      .level     (cpu_level)
   );

   // Grant decision and next state; the counter reads 0 during ISSUE so that
   // ISSUE + HOLD + IDLE spans exactly HOLDOFF_CYCLES+1 cycles.
   always_comb begin
      state_nxt_s   = state_r;
      counter_nxt_s = counter_r + 1'b1;
      grant_cpu_s   = 1'b0;
      grant_dbg_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            counter_nxt_s = '0;
            if (!fifo_empty_s && (!dbg_full_r || last_grant_r == GRANT_DBG)) begin
               grant_cpu_s = 1'b1;
               state_nxt_s = ST_ISSUE;
            end else if (dbg_full_r) begin
               grant_dbg_s = 1'b1;
               state_nxt_s = ST_ISSUE;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ISSUE: state_nxt_s = ST_HOLD;
         ST_HOLD: begin
            if (counter_r == HOLD_LAST) begin
               state_nxt_s   = ST_IDLE;
               counter_nxt_s = '0;
            end else begin
               state_nxt_s = ST_HOLD;
            end
         end
         default: begin
            state_nxt_s   = ST_HOLD;
            counter_nxt_s = '0;
         end
      endcase
   end

   // FSM state, hold-off counter and the registered controller interface.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r      <= ST_HOLD;
         counter_r    <= '0;
         last_grant_r <= GRANT_DBG;
         lcd_start_r  <= 1'b0;
         lcd_cmd_r    <= '0;
         busy_r       <= 1'b1;
      end else begin
         state_r     <= state_nxt_s;
         counter_r   <= counter_nxt_s;
         busy_r      <= (state_nxt_s != ST_IDLE);
         lcd_start_r <= grant_cpu_s || grant_dbg_s;
         if (grant_cpu_s) begin
            lcd_cmd_r    <= fifo_head_s;
            last_grant_r <= GRANT_CPU;
         end else if (grant_dbg_s) begin
            lcd_cmd_r    <= dbg_cmd_r;
            last_grant_r <= GRANT_DBG;
         end
      end
   end

   // One-entry debug holding register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dbg_full_r <= 1'b0;
         dbg_cmd_r  <= '0;
      end else if (flush || grant_dbg_s) begin
         dbg_full_r <= 1'b0;
      end else if (dbg_load_s) begin
         dbg_full_r <= 1'b1;
         dbg_cmd_r  <= lcd_cmd_t'({dbg_opcode, dbg_reg_idx, dbg_value});
      end
   end

   assign lcd_start   = lcd_start_r;
   assign lcd_opcode  = lcd_cmd_r.opcode;
   assign lcd_reg_idx = lcd_cmd_r.reg_idx;
   assign lcd_value   = lcd_cmd_r.value;
   assign busy        = busy_r;

endmodule

// File: tb/tb_lcd_cmd_scheduler.sv
// Self-checking bench for lcd_cmd_scheduler: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a model.
module tb_lcd_cmd_scheduler;
   import lcd_sched_pkg::*;

   localparam int D = 4;
   localparam int H = 8;

   logic               clk = 1'b0;
   logic               reset_n = 1'b0;
   logic               cpu_valid = 1'b0;
   logic               cpu_ready;
   logic [2:0]         cpu_opcode = '0;
   logic [3:0]         cpu_reg_idx = '0;
   logic signed [15:0] cpu_value = '0;
   logic               dbg_valid = 1'b0;
   logic               dbg_ready;
   logic [2:0]         dbg_opcode = '0;
   logic [3:0]         dbg_reg_idx = '0;
   logic signed [15:0] dbg_value = '0;
   logic               flush = 1'b0;
   logic               lcd_start;
   logic [2:0]         lcd_opcode;
   logic [3:0]         lcd_reg_idx;
   logic signed [15:0] lcd_value;
   logic               busy;
   logic [2:0]         cpu_level;

   lcd_cmd_scheduler #(.FIFO_DEPTH(D), .HOLDOFF_CYCLES(H)) dut (
      .clk(clk), .reset_n(reset_n),
      .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_opcode(cpu_opcode),
      .cpu_reg_idx(cpu_reg_idx), .cpu_value(cpu_value),
      .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_opcode(dbg_opcode),
      .dbg_reg_idx(dbg_reg_idx), .dbg_value(dbg_value),
      .flush(flush), .lcd_start(lcd_start), .lcd_opcode(lcd_opcode),
      .lcd_reg_idx(lcd_reg_idx), .lcd_value(lcd_value),
      .busy(busy), .cpu_level(cpu_level)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: a queue, a debug slot and the earliest cycle a grant is allowed.
   logic [22:0] m_q[$];
   logic        m_dbg_full;
   logic [22:0] m_dbg;
   logic        m_last_dbg;
   int          m_cyc;
   int          m_earliest;
   logic        m_start;
   logic [22:0] m_lcd;
   logic        m_crdy, m_drdy, m_take_cpu, m_take_dbg;

   always @(posedge clk) begin
      if (!reset_n) begin
         m_q.delete();
         m_dbg_full = 1'b0;
         m_dbg      = '0;
         m_last_dbg = 1'b1;
         m_cyc      = 0;
         m_earliest = H;
         m_start    = 1'b0;
         m_lcd      = '0;
      end else begin
         m_crdy     = (m_q.size() < D) && !flush;
         m_drdy     = !m_dbg_full && !flush;
         m_take_cpu = 1'b0;
         m_take_dbg = 1'b0;
         if (m_cyc >= m_earliest) begin
            if (m_q.size() > 0 && m_dbg_full) begin
               if (m_last_dbg) m_take_cpu = 1'b1;
               else m_take_dbg = 1'b1;
            end else if (m_q.size() > 0) m_take_cpu = 1'b1;
            else if (m_dbg_full) m_take_dbg = 1'b1;
         end
         m_start = m_take_cpu || m_take_dbg;
         if (m_take_cpu) begin
            m_lcd      = m_q.pop_front();
            m_last_dbg = 1'b0;
         end
         if (m_take_dbg) begin
            m_lcd      = m_dbg;
            m_dbg_full = 1'b0;
            m_last_dbg = 1'b1;
         end
         if (m_start) m_earliest = m_cyc + 1 + H;
         if (cpu_valid && m_crdy) m_q.push_back({cpu_opcode, cpu_reg_idx, cpu_value});
         if (dbg_valid && m_drdy) begin
            m_dbg_full = 1'b1;
            m_dbg      = {dbg_opcode, dbg_reg_idx, dbg_value};
         end
         if (flush) begin
            m_q.delete();
            m_dbg_full = 1'b0;
         end
         m_cyc++;
      end
   end

   // Cycle-by-cycle comparison against the model (or reset values while in reset).
   always @(negedge clk) begin
      if (!reset_n) begin
         check("rst_lcd_start", lcd_start, 0);
         check("rst_payload", {lcd_opcode, lcd_reg_idx, lcd_value}, 0);
         check("rst_busy", busy, 1);
         check("rst_cpu_level", cpu_level, 0);
         check("rst_cpu_ready", cpu_ready, 1);
         check("rst_dbg_ready", dbg_ready, 1);
      end else begin
         check("lcd_start", lcd_start, m_start);
         check("lcd_payload", {lcd_opcode, lcd_reg_idx, lcd_value}, m_lcd);
         check("busy", busy, m_cyc < m_earliest);
         check("cpu_level", cpu_level, m_q.size());
         check("cpu_ready", cpu_ready, (m_q.size() < D) && !flush);
         check("dbg_ready", dbg_ready, !m_dbg_full && !flush);
      end
   end

   int          tb_cyc;
   int          st_cyc[$];
   logic [22:0] st_pay[$];

   always @(posedge clk) begin
      if (!reset_n) tb_cyc <= 0;
      else tb_cyc <= tb_cyc + 1;
   end

   always @(negedge clk) begin
      if (reset_n && lcd_start) begin
         st_cyc.push_back(tb_cyc);
         st_pay.push_back({lcd_opcode, lcd_reg_idx, lcd_value});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_push(input logic [2:0] op, input logic [3:0] r, input logic [15:0] v);
      logic acc;
      acc         = 1'b0;
      cpu_opcode  = op;
      cpu_reg_idx = r;
      cpu_value   = v;
      cpu_valid   = 1'b1;
      for (int i = 0; i < 40 && !acc; i++) begin
         @(negedge clk);
         acc = cpu_ready;
         step();
      end
      if (!acc) begin
         n_total++;
         $display("FAIL cpu_push_timeout: cpu_ready stayed 0, required 1 (op %0d)", op);
      end
   endtask

   task automatic wait_start(input int budget, output int at, output logic [22:0] pay);
      at  = -1;
      pay = '0;
      for (int i = 0; i < budget && at < 0; i++) begin
         @(negedge clk);
         if (lcd_start) begin
            at  = tb_cyc;
            pay = {lcd_opcode, lcd_reg_idx, lcd_value};
         end
      end
   endtask

   int          at;
   logic [22:0] pay;

   initial begin
      // Boot hold-off: ADD r3 -5 pushed at cycle 2 starts at cycle 9.
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      check("boot_busy", busy, 1);
      step();
      step();
      cpu_push(OP_ADD, 4'd3, -16'sd5);
      cpu_valid = 1'b0;
      wait_start(30, at, pay);
      check("boot_start_cycle", at, 9);
      check("boot_payload", pay, {3'd1, 4'd3, 16'hFFFB});
      step();

      // Back-to-back: five pushes, starts 9 cycles apart in FIFO order.
      repeat (12) step();
      st_cyc.delete();
      st_pay.delete();
      for (int k = 0; k < 5; k++) cpu_push(3'(k), 4'(k), 16'(100 * k));
      cpu_valid = 1'b0;
      repeat (50) step();
      check("b2b_count", st_cyc.size(), 5);
      if (st_cyc.size() >= 5) begin
         for (int k = 1; k < 5; k++) check("b2b_spacing", st_cyc[k] - st_cyc[k-1], 9);
         for (int k = 0; k < 5; k++) check("b2b_order", st_pay[k], {3'(k), 4'(k), 16'(100 * k)});
      end

      // Flush during hold-off with three queued; coinciding push is refused.
      st_cyc.delete();
      st_pay.delete();
      cpu_push(OP_MUL, 4'd5, 16'd1);
      for (int k = 0; k < 3; k++) cpu_push(OP_SUB, 4'(k), 16'(k));
      cpu_opcode = OP_CLEAR;
      flush      = 1'b1;
      @(negedge clk);
      check("flush_cpu_ready", cpu_ready, 0);
      check("flush_dbg_ready", dbg_ready, 0);
      step();
      flush     = 1'b0;
      cpu_valid = 1'b0;
      @(negedge clk);
      check("flush_level", cpu_level, 0);
      step();
      repeat (20) step();
      check("flush_no_start", st_cyc.size(), 1);

      // Reset asserted during ISSUE.
      cpu_opcode  = OP_SUB;
      cpu_reg_idx = 4'd4;
      cpu_value   = 16'd9;
      cpu_valid   = 1'b1;
      step();
      cpu_value = 16'd10;
      step();
      check("issue_start_high", lcd_start, 1);
      reset_n   = 1'b0;
      cpu_valid = 1'b0;
      #1;
      check("issue_rst_start", lcd_start, 0);
      check("issue_rst_level", cpu_level, 0);
      check("issue_rst_payload", {lcd_opcode, lcd_reg_idx, lcd_value}, 0);
      check("issue_rst_busy", busy, 1);
      repeat (2) @(posedge clk);
      st_cyc.delete();
      st_pay.delete();
      #1 reset_n = 1'b1;

      // Tie right after reset: CPU LOAD first, debug DPL next.
      step();
      step();
      cpu_opcode  = OP_LOAD;
      cpu_reg_idx = 4'd1;
      cpu_value   = 16'sd7;
      cpu_valid   = 1'b1;
      dbg_opcode  = OP_DPL;
      dbg_reg_idx = 4'd2;
      dbg_value   = 16'sd100;
      dbg_valid   = 1'b1;
      step();
      cpu_valid = 1'b0;
      dbg_valid = 1'b0;
      repeat (30) step();
      check("tie_count", st_cyc.size(), 2);
      if (st_cyc.size() >= 2) begin
         check("tie_first_cycle", st_cyc[0], 9);
         check("tie_first_payload", st_pay[0], {3'd0, 4'd1, 16'd7});
         check("tie_second_cycle", st_cyc[1], 18);
         check("tie_second_payload", st_pay[1], {3'd7, 4'd2, 16'd100});
      end

      // Randomized traffic: ties, full queue, pointer wrap, occasional flush.
      for (int i = 0; i < 600; i++) begin
         cpu_valid   = 1'($urandom_range(0, 1));
         cpu_opcode  = 3'($urandom);
         cpu_reg_idx = 4'($urandom);
         cpu_value   = 16'($urandom);
         dbg_valid   = ($urandom_range(0, 3) == 0);
         dbg_opcode  = 3'($urandom);
         dbg_reg_idx = 4'($urandom);
         dbg_value   = 16'($urandom);
         flush       = ($urandom_range(0, 49) == 0);
         step();
      end
      cpu_valid = 1'b0;
      dbg_valid = 1'b0;
      flush     = 1'b0;
      repeat (3) step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
